// File: rtl/ripple_add_seq_ctrl.sv
// Area-reduced add/subtract: one SLICE-bit ripple slice reused over WIDTH/SLICE cycles,
// least-significant slice first, with the inter-slice carry held in a register.
module ripple_add_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ovf
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic [SLICE:0]   slice_sum;
    logic             slice_cin_msb;
    logic             accept;
    logic             last;

    assign accept = (state_q == StIdle) && start;
    assign last   = (state_q == StRun) && (k_q == KLast);

    // Operands are shifted right each RUN cycle, so the active slice is always the low bits.
    always_comb begin
        slice_sum     = {1'b0, op_a_q[SLICE-1:0]} + {1'b0, op_b_q[SLICE-1:0]}
                      + {{SLICE{1'b0}}, carry_q};
        slice_cin_msb = op_a_q[SLICE-1] ^ op_b_q[SLICE-1] ^ slice_sum[SLICE-1];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == StIdle);
        done  = (state_q == StDone);
    end

    always_comb begin
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        if (accept) begin
            op_a_d  = X;
            op_b_d  = sub ? ~Y : Y;
            carry_d = sub;
            k_d     = '0;
        end else if (state_q == StRun) begin
            op_a_d  = op_a_q >> SLICE;
            op_b_d  = op_b_q >> SLICE;
            carry_d = slice_sum[SLICE];
            k_d     = k_q + 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                if (k_q == KW'(i)) s_d[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            end
            if (last) begin
                co_d  = slice_sum[SLICE];
                ovf_d = slice_cin_msb ^ slice_sum[SLICE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign S   = s_q;
    assign Co  = co_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_ripple_add_seq_ctrl.sv
// Bench for ripple_add_seq_ctrl: three instances (SLICE 8, 32, 1) against an arithmetic model.
module tb_ripple_add_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sub;
    logic [31:0] X, Y;
    logic [2:0]  start_w;
    logic [2:0]  ready_w, done_w, co_w, ovf_w;
    logic [31:0] s_w [3];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lat [3] = '{4, 1, 32};

    always #5 clk = ~clk;

    ripple_add_seq_ctrl #(.WIDTH(32), .SLICE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .sub(sub), .X(X), .Y(Y),
        .ready(ready_w[0]), .done(done_w[0]), .S(s_w[0]), .Co(co_w[0]), .Ovf(ovf_w[0]));
    ripple_add_seq_ctrl #(.WIDTH(32), .SLICE(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .sub(sub), .X(X), .Y(Y),
        .ready(ready_w[1]), .done(done_w[1]), .S(s_w[1]), .Co(co_w[1]), .Ovf(ovf_w[1]));
    ripple_add_seq_ctrl #(.WIDTH(32), .SLICE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .sub(sub), .X(X), .Y(Y),
        .ready(ready_w[2]), .done(done_w[2]), .S(s_w[2]), .Co(co_w[2]), .Ovf(ovf_w[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {ovf, co, s} from plain two's-complement arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic sb);
        logic [32:0] t;
        logic        ovf;
        t   = {1'b0, x} + {1'b0, (sb ? ~y : y)} + {32'd0, sb};
        ovf = sb ? ((x[31] != y[31]) && (t[31] != x[31]))
                 : ((x[31] == y[31]) && (t[31] != x[31]));
        return {ovf, t[32], t[31:0]};
    endfunction

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic sb,
                         input bit all3);
        int          lat [3];
        int          nd  [3];
        logic [31:0] cs  [3];
        logic        cc  [3];
        logic        cv  [3];
        logic [33:0] m;
        int          ni;
        m  = model(x, y, sb);
        ni = all3 ? 3 : 1;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; nd[i] = 0; cs[i] = '0; cc[i] = 1'b0; cv[i] = 1'b0;
        end
        @(negedge clk);
        X = x; Y = y; sub = sb;
        start_w = all3 ? 3'b111 : 3'b001;
        @(posedge clk);
        #1;
        start_w = 3'b000;
        X = $urandom; Y = $urandom; sub = 1'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    nd[i]++;
                    if (nd[i] == 1) begin
                        lat[i] = c; cs[i] = s_w[i]; cc[i] = co_w[i]; cv[i] = ovf_w[i];
                    end
                end
            end
        end
        for (int i = 0; i < ni; i++) begin
            check($sformatf("lat[%0d]", i), 64'(lat[i]), 64'(exp_lat[i]));
            check($sformatf("ndone[%0d]", i), 64'(nd[i]), 64'd1);
            check($sformatf("S[%0d]", i), 64'(cs[i]), 64'(m[31:0]));
            check($sformatf("Co[%0d]", i), 64'(cc[i]), 64'(m[32]));
            check($sformatf("Ovf[%0d]", i), 64'(cv[i]), 64'(m[33]));
            check($sformatf("S_hold[%0d]", i), 64'(s_w[i]), 64'(m[31:0]));
            check($sformatf("ready[%0d]", i), 64'(ready_w[i]), 64'd1);
        end
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; start_w = 3'b000; sub = 1'b0; X = '0; Y = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready[%0d]", i), 64'(ready_w[i]), 64'd1);
            check($sformatf("rst_done[%0d]", i), 64'(done_w[i]), 64'd0);
            check($sformatf("rst_S[%0d]", i), 64'(s_w[i]), 64'd0);
            check($sformatf("rst_Co[%0d]", i), 64'(co_w[i]), 64'd0);
            check($sformatf("rst_Ovf[%0d]", i), 64'(ovf_w[i]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);

        // start held high with operands changing during RUN
        @(negedge clk);
        X = 32'h0000_1234; Y = 32'h0000_0F00; sub = 1'b0; start_w[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 6) begin
                X = 32'hFFFF_FFF0; Y = 32'h0000_0020; sub = 1'b0;
            end else begin
                X = $urandom; Y = $urandom; sub = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (c <= 5) check($sformatf("t4_done_c%0d", c), 64'(done_w[0]), 64'(c == 4));
            if (c == 4) check("t4_S", 64'(s_w[0]), 64'h2134);
            if (c == 5) check("t4_ready_idle", 64'(ready_w[0]), 64'd1);
            if (c == 6) check("t4_reaccept", 64'(ready_w[0]), 64'd0);
        end
        start_w[0] = 1'b0;
        X = $urandom; Y = $urandom;
        repeat (4) @(posedge clk);
        #1;
        check("t4_done2", 64'(done_w[0]), 64'd1);
        check("t4_S2", 64'(s_w[0]), 64'h10);
        check("t4_Co2", 64'(co_w[0]), 64'd1);
        repeat (3) @(posedge clk);

        // reset while RUN is on slice 2
        @(negedge clk);
        X = 32'h1111_1111; Y = 32'h2222_2222; sub = 1'b0; start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_S", 64'(s_w[0]), 64'd0);
        check("t5_Co", 64'(co_w[0]), 64'd0);
        check("t5_Ovf", 64'(ovf_w[0]), 64'd0);
        check("t5_ready", 64'(ready_w[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) nd++;
        end
        check("t5_no_done", 64'(nd), 64'd0);
        do_op(32'd3, 32'd4, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            do_op($urandom, $urandom, 1'($urandom), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
